// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller: hazard sources
// in, freeze/bubble/flush controls and debug/perf status out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_src1;
    logic [4:0]       id_src2;
    logic             id_uses_src2;
    logic [4:0]       exe_dest;
    logic             exe_mem_to_reg;
    logic             exe_reg_write;
    logic [1:0]       exe_jump;
    logic             mem_access;
    logic             cache_ready;

    logic             pc_freeze;
    logic             if_id_freeze;
    logic             id_exe_freeze;
    logic             exe_mem_freeze;
    logic             id_exe_bubble;
    logic             if_id_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic             miss_timeout;

    // Datapath side: presents hazard sources, consumes control
    modport master (
        output id_src1, id_src2, id_uses_src2, exe_dest, exe_mem_to_reg,
               exe_reg_write, exe_jump, mem_access, cache_ready,
        input  pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze,
               id_exe_bubble, if_id_flush, state, stall_cnt, miss_timeout
    );

    // Controller side
    modport slave (
        input  id_src1, id_src2, id_uses_src2, exe_dest, exe_mem_to_reg,
               exe_reg_write, exe_jump, mem_access, cache_ready,
        output pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze,
               id_exe_bubble, if_id_flush, state, stall_cnt, miss_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: cache-miss freezes beat
// jump flushes, which beat load-use bubbles; jumps seen during a miss are replayed.
module pipeline_hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_b,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MISS       = 2'd1,
        ST_FLUSH_PEND = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MISS_LIMIT = CNT_W'(MISS_TIMEOUT);

    state_e           state_q, state_d;
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             miss_timeout_q, miss_timeout_d;

    logic miss, jmp, lu;
    logic freeze_all, pc_hold, if_id_hold, bubble, flush;

    assign miss = hz.mem_access & ~hz.cache_ready;
    assign jmp  = |hz.exe_jump;
    assign lu   = hz.exe_mem_to_reg & hz.exe_reg_write & (hz.exe_dest != 5'd0) &
                  ((hz.exe_dest == hz.id_src1) |
                   (hz.id_uses_src2 & (hz.exe_dest == hz.id_src2)));

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        miss_cnt_d   = '0;
        freeze_all   = 1'b0;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        bubble       = 1'b0;
        flush        = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (miss) begin
                    // The detecting cycle already counts as the first stalled cycle
                    freeze_all   = 1'b1;
                    state_d      = ST_MISS;
                    flush_pend_d = jmp;
                    miss_cnt_d   = CNT_W'(1);
                end else if (jmp) begin
                    flush  = 1'b1;
                    bubble = 1'b1;
                end else if (lu) begin
                    pc_hold    = 1'b1;
                    if_id_hold = 1'b1;
                    bubble     = 1'b1;
                end
            end
            ST_MISS: begin
                flush_pend_d = flush_pend_q | jmp;
                if (!hz.cache_ready) begin
                    freeze_all = 1'b1;
                    miss_cnt_d = (miss_cnt_q == MISS_LIMIT) ? miss_cnt_q
                                                            : miss_cnt_q + CNT_W'(1);
                end else begin
                    state_d = flush_pend_d ? ST_FLUSH_PEND : ST_RUN;
                end
            end
            ST_FLUSH_PEND: begin
                if (miss) begin
                    // Re-entering a stall: keep the flush owed for later
                    freeze_all = 1'b1;
                    state_d    = ST_MISS;
                    miss_cnt_d = CNT_W'(1);
                end else begin
                    flush        = 1'b1;
                    bubble       = 1'b1;
                    state_d      = ST_RUN;
                    flush_pend_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_RUN;
                flush_pend_d = 1'b0;
            end
        endcase
    end

    // Controls are masked while reset is held so the pipeline cannot stall mid-reset
    assign hz.pc_freeze      = rst_b & (freeze_all | pc_hold);
    assign hz.if_id_freeze   = rst_b & (freeze_all | if_id_hold);
    assign hz.id_exe_freeze  = rst_b & freeze_all;
    assign hz.exe_mem_freeze = rst_b & freeze_all;
    assign hz.id_exe_bubble  = rst_b & bubble;
    assign hz.if_id_flush    = rst_b & flush;
    assign hz.state          = state_q;
    assign hz.stall_cnt      = stall_cnt_q;
    assign hz.miss_timeout   = miss_timeout_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz.pc_freeze && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        miss_timeout_d = miss_timeout_q | (miss_cnt_d == MISS_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= ST_RUN;
            flush_pend_q   <= 1'b0;
            miss_cnt_q     <= '0;
            stall_cnt_q    <= '0;
            miss_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_pend_q   <= flush_pend_d;
            miss_cnt_q     <= miss_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            miss_timeout_q <= miss_timeout_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector scoreboard bench for pipeline_hazard_ctrl (MISS_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_b;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(16), .MISS_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .hz    (bus)
    );

    typedef struct packed {
        logic [3:0]  fz;
        logic        bub;
        logic        fl;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec   = 0;

    task automatic drv(input logic rb, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u2, input logic [4:0] d, input logic m2r,
                       input logic rw, input logic [1:0] j, input logic ma,
                       input logic cr);
        rst_b              = rb;
        bus.id_src1        = s1;
        bus.id_src2        = s2;
        bus.id_uses_src2   = u2;
        bus.exe_dest       = d;
        bus.exe_mem_to_reg = m2r;
        bus.exe_reg_write  = rw;
        bus.exe_jump       = j;
        bus.mem_access     = ma;
        bus.cache_ready    = cr;
    endtask

    task automatic exp_push(input logic [3:0] fz, input logic bub, input logic fl,
                            input logic [1:0] st, input logic [15:0] cnt,
                            input logic to);
        exp_t e;
        e.fz = fz; e.bub = bub; e.fl = fl; e.st = st; e.cnt = cnt; e.to = to;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int v, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL vec%0d %s: got %0h required %0h", v, name, act, req);
        end
    endtask

    // Monitor: compares one expected entry per falling edge
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                m = exp_q.pop_front();
                vec++;
                chk("freeze", vec, 32'({bus.pc_freeze, bus.if_id_freeze,
                                        bus.id_exe_freeze, bus.exe_mem_freeze}), 32'(m.fz));
                chk("bubble", vec, 32'(bus.id_exe_bubble), 32'(m.bub));
                chk("flush", vec, 32'(bus.if_id_flush), 32'(m.fl));
                chk("state", vec, 32'(bus.state), 32'(m.st));
                chk("stall_cnt", vec, 32'(bus.stall_cnt), 32'(m.cnt));
                chk("miss_timeout", vec, 32'(bus.miss_timeout), 32'(m.to));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        @(posedge clk);
        #1;
        // Reset held, then released idle
        drv(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 0, 0);
        // Load-use on rs: one bubble, then NOP in EXE
        drv(1, 8, 0, 0, 8, 1, 1, 2'b00, 0, 0); exp_push(4'b1100, 1, 0, 0, 0, 0);
        drv(1, 8, 0, 0, 0, 0, 0, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 1, 0);
        // No false hazards
        drv(1, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 1, 0);
        drv(1, 3, 9, 0, 9, 1, 1, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 1, 0);
        drv(1, 3, 9, 1, 9, 1, 1, 2'b00, 0, 0); exp_push(4'b1100, 1, 0, 0, 1, 0);
        drv(1, 8, 0, 0, 8, 1, 0, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 2, 0);
        // Jump beats load-use
        drv(1, 8, 0, 0, 8, 1, 1, 2'b01, 0, 0); exp_push(4'b0000, 1, 1, 0, 2, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 2, 0);
        // Cache miss for 5 cycles; timeout (4) trips after the 4th
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 0, 2, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 1, 3, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 1, 4, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 1, 5, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 1, 6, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1); exp_push(4'b0000, 0, 0, 1, 7, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 7, 1);
        // Async reset with a miss present clears everything
        drv(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b0000, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 0, 0);
        // Jump arriving during a 3-cycle miss is replayed after ready
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0); exp_push(4'b1111, 0, 0, 1, 1, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0); exp_push(4'b1111, 0, 0, 1, 2, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b10, 1, 1); exp_push(4'b0000, 0, 0, 1, 3, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0); exp_push(4'b0000, 1, 1, 2, 3, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 3, 0);
        // Six-cycle miss: timeout after 4th, load-use ignored, reset mid-stall
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 0, 3, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 1, 4, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 1, 5, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 1, 6, 0);
        drv(1, 8, 0, 0, 8, 1, 1, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 1, 7, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b1111, 0, 0, 1, 8, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); exp_push(4'b0000, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0); exp_push(4'b0000, 0, 0, 0, 0, 0);

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d entries left required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
